// File: rtl/cvxif_mac4b_instr_pkg.sv
// Shared CV-X-IF types, the MAC queue entry and state types, and the default decode table.
package cvxif_mac4b_instr_pkg;

    localparam int X_NUM_RS    = 3;
    localparam int X_ID_WIDTH  = 4;
    localparam int X_RFR_WIDTH = 32;
    localparam int INSTR_IDX_W = 4;

    typedef struct packed {
        logic [31:0]                             instr;
        logic [1:0]                              mode;
        logic [X_ID_WIDTH-1:0]                   id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]    rs;
        logic [X_NUM_RS-1:0]                     rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  x_commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [31:0]         mask;
        logic [31:0]         instr;
        logic [X_NUM_RS-1:0] rs_valid;
        x_issue_resp_t       resp;
    } copro_issue_resp_t;

    typedef struct packed {
        logic [INSTR_IDX_W-1:0]               instr_idx;
        logic [4:0]                           rd;
        logic [X_ID_WIDTH-1:0]                id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
        logic                                 writeback;
    } mac_op_t;

    typedef enum logic [1:0] {
        FREE,
        PENDING,
        COMMITTED,
        KILLED
    } entry_state_e;

    // Entry 0 is the MAC (custom-3, funct3=0, funct7=0); entry 1 catches any custom-3 op, so the two overlap.
    localparam copro_issue_resp_t [1:0] DEFAULT_COPRO_INSTR = {
        copro_issue_resp_t'{
            mask:     32'h0000_007F,
            instr:    32'h0000_007B,
            rs_valid: 3'b001,
            resp:     '{accept: 1'b1, writeback: 1'b0, default: 1'b0}
        },
        copro_issue_resp_t'{
            mask:     32'hFE00_707F,
            instr:    32'h0000_007B,
            rs_valid: 3'b011,
            resp:     '{accept: 1'b1, writeback: 1'b1, default: 1'b0}
        }
    };

endpackage

// File: rtl/mac_issue_decode.sv
// Combinational priority decoder of an offloaded instruction against the compile-time table.
module mac_issue_decode
    import cvxif_mac4b_instr_pkg::*;
#(
    parameter int unsigned                        NbInstr    = 2,
    parameter copro_issue_resp_t [NbInstr-1:0]    CoproInstr = DEFAULT_COPRO_INSTR
) (
    input  logic                      valid,
    input  logic [31:0]               instr,
    input  logic [X_NUM_RS-1:0]       rs_valid,
    output logic [NbInstr-1:0]        sel,
    output logic [INSTR_IDX_W-1:0]    idx,
    output x_issue_resp_t             resp,
    output logic [4:0]                rd,
    output logic                      multi_match
);

    always_comb begin
        sel  = '0;
        idx  = '0;
        resp = '0;
        for (int i = 0; i < int'(NbInstr); i++) begin
            sel[i] = ((CoproInstr[i].mask & instr) == CoproInstr[i].instr) &&
                     ((rs_valid & CoproInstr[i].rs_valid) == CoproInstr[i].rs_valid);
        end
        // Walking downwards leaves the lowest matching entry as the winner.
        for (int i = int'(NbInstr) - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx  = INSTR_IDX_W'(i);
                resp = CoproInstr[i].resp;
            end
        end
        if (!valid) begin
            resp = '0;
        end
    end

    assign rd          = instr[11:7];
    assign multi_match = valid && ((sel & (sel - NbInstr'(1))) != '0);

endmodule

// File: rtl/cvxif_issue_queue_mac.sv
// CV-X-IF issue decoder with an in-order commit-tracked queue feeding the MAC execution unit.
module cvxif_issue_queue_mac
    import cvxif_mac4b_instr_pkg::*;
#(
    parameter int unsigned                        NbInstr    = 2,
    parameter copro_issue_resp_t [NbInstr-1:0]    CoproInstr = DEFAULT_COPRO_INSTR,
    parameter int unsigned                        Depth      = 4,
    parameter int unsigned                        NrRs       = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          x_issue_valid_i,
    output logic          x_issue_ready_o,
    input  x_issue_req_t  x_issue_req_i,
    output x_issue_resp_t x_issue_resp_o,
    input  logic          x_commit_valid_i,
    input  x_commit_t     x_commit_i,
    output logic          op_valid_o,
    input  logic          op_ready_i,
    output mac_op_t       op_o,
    output logic          multi_match_o,
    output logic          full_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    entry_state_e           slot_state [Depth];
    mac_op_t                slot_op    [Depth];
    logic [PtrW-1:0]        head;
    logic [PtrW-1:0]        tail;
    logic [CntW-1:0]        count;

    logic [NbInstr-1:0]     dec_sel;
    logic [INSTR_IDX_W-1:0] dec_idx;
    x_issue_resp_t          dec_resp;
    logic [4:0]             dec_rd;
    entry_state_e           head_state;
    mac_op_t                new_op;
    logic                   push;
    logic                   pop;
    logic                   unused_bits;

    mac_issue_decode #(
        .NbInstr    (NbInstr),
        .CoproInstr (CoproInstr)
    ) u_decode (
        .valid       (x_issue_valid_i),
        .instr       (x_issue_req_i.instr),
        .rs_valid    (x_issue_req_i.rs_valid),
        .sel         (dec_sel),
        .idx         (dec_idx),
        .resp        (dec_resp),
        .rd          (dec_rd),
        .multi_match (multi_match_o)
    );

    assign x_issue_resp_o  = dec_resp;
    assign full_o          = (count == CntW'(Depth));
    assign x_issue_ready_o = !full_o;
    assign push            = x_issue_valid_i && x_issue_ready_o && dec_resp.accept;

    // A killed head is retired silently, taking the cycle's single head action.
    assign head_state = slot_state[head];
    assign op_valid_o = (head_state == COMMITTED);
    assign pop        = (op_valid_o && op_ready_i) || (head_state == KILLED);
    assign op_o       = slot_op[head];

    assign unused_bits = ^{x_issue_req_i.mode, dec_sel};

    always_comb begin
        new_op           = '0;
        new_op.instr_idx = dec_idx;
        new_op.rd        = dec_rd;
        new_op.id        = x_issue_req_i.id;
        new_op.writeback = dec_resp.writeback;
        for (int r = 0; r < X_NUM_RS; r++) begin
            if (r < int'(NrRs)) begin
                new_op.rs[r] = x_issue_req_i.rs[r];
            end
        end
    end

    // Commit only sees PENDING slots, so an entry pushed this same cycle is never matched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                slot_state[i] <= FREE;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (x_commit_valid_i) begin
                for (int i = 0; i < int'(Depth); i++) begin
                    if (slot_state[i] == PENDING && slot_op[i].id == x_commit_i.id) begin
                        slot_state[i] <= x_commit_i.x_commit_kill ? KILLED : COMMITTED;
                    end
                end
            end
            if (pop) begin
                slot_state[head] <= FREE;
                head             <= head + 1'b1;
            end
            if (push) begin
                slot_state[tail] <= PENDING;
                tail             <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                slot_op[i] <= '0;
            end
        end else if (push) begin
            slot_op[tail] <= new_op;
        end
    end

    a_op_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (op_valid_o && !op_ready_i) |=> $stable(op_o));

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> !full_o);

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= CntW'(Depth));

endmodule
